// File: rtl/spi_bridge.sv
// SPI mode-0 target that masters the register-file bus.
// Each chip-select frame carries one access: a command byte (write flag, reserved bit, address)
// followed by one data byte. The data byte is either shifted in on MOSI or shifted out on MISO.
// All SPI pins are synchronized into clk. SPI edges are detected from the synchronized sclk.

module spi_bridge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_write,
    input  logic [DATA_W-1:0] data_read
);

    localparam int unsigned CntW = 5;

    typedef enum logic [2:0] {StIdle, StCmd, StWdata, StRdata, StDone} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_cur, cs_cur, mosi_cur;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [DATA_W-1:0] rx_q, rx_d, rx_shift;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dw_q, dw_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              miso_q, miso_d;
    logic              rd_cap_q;

    assign sclk_cur  = sclk_sync_q[SYNC_STAGES-1];
    assign cs_cur    = cs_sync_q[SYNC_STAGES-1];
    assign mosi_cur  = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_cur & ~sclk_prev_q;
    assign sclk_fall = ~sclk_cur & sclk_prev_q;
    assign cs_fall   = ~cs_cur & cs_prev_q;
    assign cs_rise   = cs_cur & ~cs_prev_q;

    assign rx_shift = {rx_q[DATA_W-2:0], mosi_cur};
    // Saturating rise counter; it never wraps back into a valid bit position.
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    // Pin synchronizers and previous-value flops for edge detection.
    // cs reset value is 0, so cs_n still low when reset is released is not seen as a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_cur;
            cs_prev_q   <= cs_cur;
        end
    end

    // Frame state, shift registers and registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rx_q     <= '0;
            tx_q     <= '0;
            addr_q   <= '0;
            dw_q     <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            miso_q   <= 1'b0;
            rd_cap_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rx_q     <= rx_d;
            tx_q     <= tx_d;
            addr_q   <= addr_d;
            dw_q     <= dw_d;
            read_q   <= read_d;
            write_q  <= write_d;
            miso_q   <= miso_d;
            rd_cap_q <= read_q;
        end
    end

    // Next-state and output decode. A cs_n rise aborts any frame in progress.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        addr_d  = addr_q;
        dw_d    = dw_q;
        read_d  = 1'b0;
        write_d = 1'b0;
        miso_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d = StCmd;
                    cnt_d   = '0;
                    rx_d    = '0;
                end
            end

            StCmd: begin
                if (cs_rise) begin
                    state_d = StIdle;
                end else if (sclk_rise) begin
                    rx_d  = rx_shift;
                    cnt_d = cnt_inc;
                    if (cnt_q == CntW'(DATA_W - 1)) begin
                        addr_d = rx_shift[ADDR_W-1:0];
                        if (rx_shift[DATA_W-1]) begin
                            state_d = StWdata;
                        end else begin
                            state_d = StRdata;
                            read_d  = 1'b1;
                        end
                    end
                end
            end

            StWdata: begin
                if (cs_rise) begin
                    state_d = StIdle;
                end else if (sclk_rise) begin
                    rx_d  = rx_shift;
                    cnt_d = cnt_inc;
                    if (cnt_q == CntW'(2 * DATA_W - 1)) begin
                        dw_d    = rx_shift;
                        write_d = 1'b1;
                        state_d = StDone;
                    end
                end
            end

            StRdata: begin
                miso_d = miso_q;
                if (cs_rise) begin
                    state_d = StIdle;
                    miso_d  = 1'b0;
                end else begin
                    // Read data arrives the clk after the strobe; load it before the first fall.
                    if (rd_cap_q) begin
                        tx_d = data_read;
                    end
                    if (sclk_fall) begin
                        miso_d = tx_q[DATA_W-1];
                        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        cnt_d = cnt_inc;
                        if (cnt_q == CntW'(2 * DATA_W - 1)) begin
                            state_d = StDone;
                            miso_d  = 1'b0;
                        end
                    end
                end
            end

            StDone: begin
                if (cs_rise) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign miso       = miso_q;
    assign read       = read_q;
    assign write      = write_q;
    assign addr       = addr_q;
    assign data_write = dw_q;

endmodule

// File: doc/spi_bridge.md
Name: spi_bridge

Overview:
SPI target (mode 0, CPOL=0/CPHA=0) that masters the register-file bus: it decodes SPI frames into single-cycle read/write strobes with addr/data_write, and shifts data_read back out on MISO. It sits between the chip pins and the register bank and is the only initiator on that bus. One register access per chip-select frame.

Parameters:
SYNC_STAGES, 2, flops in the synchronizers on sclk, cs_n and mosi (min 2).
ADDR_W, 6, register-bus address width; addr[5] selects the high byte of 16-bit registers.
DATA_W, 8, register-bus data width and SPI data byte length.

Ports:
clk  in  1  system clock, sole clock domain
rst_n  in  1  asynchronous active-low reset
sclk  in  1  SPI clock, asynchronous to clk
cs_n  in  1  SPI chip select, active low, asynchronous
mosi  in  1  SPI data in
miso  out  1  SPI data out, driven (no tristate)
read  out  1  register read strobe, one clk wide
write  out  1  register write strobe, one clk wide
addr  out  ADDR_W  register address
data_write  out  DATA_W  register write data
data_read  in  DATA_W  register read data, valid the clk after read

Behaviour:
- Reset: read=0, write=0, addr=0, data_write=0, miso=0, state=IDLE, bit counter=0, shift registers=0. Asynchronous assert, synchronous deassert release.
- sclk, cs_n and mosi pass through SYNC_STAGES flops. Edges are detected on synchronized sclk: rise = cur & ~prev, fall = ~cur & prev. mosi is sampled on the detected rise, using the same synchronizer depth.
- Required SPI rate: sclk period >= 8 clk periods, each phase >= 4 clk. Rates above this are unsupported.
- Frame format, MSB first:
  - Byte 0 (command): bit7=1 is a write, 0 is a read. Bit6 is reserved and ignored. Bits5:0 form addr.
  - Byte 1: write data (MOSI) or read data (MISO).
- States: IDLE, CMD, WDATA, RDATA, DONE.
  - IDLE -> CMD when synchronized cs_n falls; bit counter cleared.
  - CMD: shift mosi on each rise. On the 8th rise, latch addr=cmd[5:0]. If bit7=1, go to WDATA. If bit7=0, assert read for 1 clk on the following clk, then go to RDATA.
  - RDATA: data_read is captured into the TX shift register 2 clk after the read strobe, which is before the 8th sclk fall. On the 8th fall, miso=data[7]. Each later fall shifts out the next bit. After the 16th rise, go to DONE.
  - WDATA: shift mosi on each rise. On the 16th rise, latch data_write; write=1 for exactly 1 clk on the next clk; go to DONE.
  - DONE: further sclk edges are ignored and miso=0. Return to IDLE when synchronized cs_n rises.
- cs_n rising in any state other than DONE aborts the frame:
  - go to IDLE, no write strobe, miso=0;
  - a read strobe already issued is not retracted, since reads have no side effects.
- miso=0 whenever cs_n is high and throughout CMD, WDATA and DONE.
- addr and data_write hold their last values between frames. They change only at the latch points above and stay stable during and after the strobe.
- read and write are never high in the same cycle. At most one strobe is issued per frame.
- cs_n falling while the FSM is in IDLE always starts a fresh frame. The bit counter is 5 bits and saturates; it does not wrap.

Test Plan:
- Write frame: cmd 0x84, data 0x0A at sclk=clk/8. Expect exactly one write pulse, addr=0x04, data_write=0x0A, read stays 0.
- Read frame: cmd 0x07, with the bench regs model returning 0x3C. Expect one read pulse with addr=0x07, and MISO bits 0,0,1,1,1,1,0,0 sampled on byte-1 rises.
- High-byte and reserved bit: cmd 0xE8 (bit6 set), data 0x12. Expect addr=0x28, data_write=0x12, one write pulse.
- Abort: write frame with cs_n deasserted after 12 bits. Expect no write pulse, FSM in IDLE, and addr still latched from the command.
- Overlong and back-to-back: 24-bit write frame, then an immediate read frame. Expect a single write using the first data byte, extra bits ignored, and a correct read result in the second frame.
- Reset mid-frame: rst_n low during WDATA. Expect all outputs 0 immediately, no strobe after release, and the next full frame working normally.
